// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_pkg
// Brief    : Shared constants and helpers for the bs_gnrtr_n_rbtr endpoint.
// Revision : 1.0 - initial release
// ============================================================================
package bus_pkg;

    localparam int ADDR_W = 8;
    localparam int PKT_W  = 16;
    localparam logic [ADDR_W-1:0] BROADCAST_DEF = 8'b1000_1111;

    function automatic logic [ADDR_W-1:0] get_dest(input logic [PKT_W-1:0] pkt);
        return pkt[PKT_W-1 -: ADDR_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_fifo.sv
`default_nettype none
// ============================================================================
// Module   : bus_fifo
// Brief    : First-word-fall-through FIFO with occupancy count; a write is
//            accepted when full if a read happens in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module bus_fifo #(
    parameter int width = 16,
    parameter int depth = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_i,
    input  logic [width-1:0]           wdata_i,
    input  logic                       rd_i,
    output logic [width-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(depth+1)-1:0] count_o
);

    localparam int PTR_W = $clog2(depth);
    localparam int CNT_W = $clog2(depth+1);

    logic [width-1:0] mem_q [depth];
    logic [PTR_W-1:0] wptr_q, rptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, empty_q;
    logic             w_wr_ok, w_rd_ok;

    always_comb begin
        w_rd_ok = rd_i & ~empty_q;
        // When full the FIFO cannot be empty, so rd_i alone frees the slot.
        w_wr_ok = wr_i & (~full_q | rd_i);
        count_d = count_q;
        if (w_wr_ok && !w_rd_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (w_rd_ok && !w_wr_ok) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < depth; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (w_wr_ok) begin
                mem_q[wptr_q] <= wdata_i;
                wptr_q        <= wptr_q + PTR_W'(1);
            end
            if (w_rd_ok) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(depth));
            empty_q <= (count_d == '0);
        end
    end

    assign rdata_o = mem_q[rptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/bus_dev_endpoint.sv
`default_nettype none
// ============================================================================
// Module   : bus_dev_endpoint
// Brief    : Device-side bus endpoint: TX FIFO popped by the arbiter, RX FIFO
//            filled by the arbiter, sticky error flags. Define
//            BUS_DEV_ADDR_FILTER_EN to accept only pushes addressed to id or
//            broadcast.
// Revision : 1.0 - initial release
// ============================================================================
module bus_dev_endpoint
    import bus_pkg::*;
#(
    parameter int                pckg_sz   = 16,
    parameter int                depth     = 8,
    parameter logic [ADDR_W-1:0] id        = 8'd0,
    parameter logic [ADDR_W-1:0] broadcast = BROADCAST_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       tx_wr,
    input  logic [pckg_sz-1:0]         tx_data,
    output logic                       tx_full,
    output logic [$clog2(depth+1)-1:0] tx_count,
    output logic                       pndng,
    output logic [pckg_sz-1:0]         D_pop,
    input  logic                       pop,
    input  logic                       push,
    input  logic [pckg_sz-1:0]         D_push,
    input  logic                       rx_rd,
    output logic                       rx_valid,
    output logic [pckg_sz-1:0]         rx_data,
    output logic [$clog2(depth+1)-1:0] rx_count,
    output logic [2:0]                 err
);

`ifdef BUS_DEV_ADDR_FILTER_EN
    localparam bit c_FILTER_EN = 1'b1;
`else
    localparam bit c_FILTER_EN = 1'b0;
`endif

    logic              w_tx_empty, w_rx_empty, w_rx_full;
    logic [ADDR_W-1:0] w_dest;
    logic              w_rx_accept;
    logic [2:0]        err_q, err_d;

    assign w_dest      = D_push[pckg_sz-1 -: ADDR_W];
    assign w_rx_accept = push & (~c_FILTER_EN | (w_dest == id) | (w_dest == broadcast));

    bus_fifo #(.width(pckg_sz), .depth(depth)) u_tx_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .wr_i    (tx_wr),
        .wdata_i (tx_data),
        .rd_i    (pop),
        .rdata_o (D_pop),
        .full_o  (tx_full),
        .empty_o (w_tx_empty),
        .count_o (tx_count)
    );

    bus_fifo #(.width(pckg_sz), .depth(depth)) u_rx_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .wr_i    (w_rx_accept),
        .wdata_i (D_push),
        .rd_i    (rx_rd),
        .rdata_o (rx_data),
        .full_o  (w_rx_full),
        .empty_o (w_rx_empty),
        .count_o (rx_count)
    );

    always_comb begin
        err_d    = err_q;
        err_d[0] = err_q[0] | (tx_wr & tx_full & ~pop);
        err_d[1] = err_q[1] | (pop & w_tx_empty);
        err_d[2] = err_q[2] | (w_rx_accept & w_rx_full & ~rx_rd);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign pndng    = ~w_tx_empty;
    assign rx_valid = ~w_rx_empty;
    assign err      = err_q;

endmodule
`default_nettype wire

// File: doc/bus_dev_endpoint.md
# bus_dev_endpoint

Device-side endpoint for the `bs_gnrtr_n_rbtr` bus: one instance per bus port, owning the FIFO the arbiter pops from and the FIFO it pushes into. Local logic enqueues outbound packets; the endpoint raises `pndng`, holds the head packet on `D_pop`, and dequeues on the bus `pop`. Inbound `push`/`D_push` beats are stored for local readout, with an optional destination filter. It is the synthesizable counterpart of the behavioural bench driver and replaces it in system-level builds.

## Interface
- `pckg_sz`, 16, packet width; bits `[pckg_sz-1 -: 8]` are the destination address.
- `depth`, 8, entries per FIFO, power of two, ≥2.
- `id`, 0, this device's bus address (8 bits).
- `broadcast`, 8'b1000_1111, broadcast destination address.
- `clk`  in  1  system clock, all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset).
- `tx_wr`  in  1  local enqueue strobe.
- `tx_data`  in  pckg_sz  local outbound packet.
- `tx_full`  out  1  TX FIFO full.
- `tx_count`  out  $clog2(depth+1)  TX occupancy.
- `pndng`  out  1  TX FIFO not empty (to arbiter).
- `D_pop`  out  pckg_sz  TX head packet (to arbiter).
- `pop`  in  1  arbiter dequeue strobe.
- `push`  in  1  arbiter delivery strobe.
- `D_push`  in  pckg_sz  delivered packet.
- `rx_rd`  in  1  local dequeue strobe.
- `rx_valid`  out  1  RX FIFO not empty.
- `rx_data`  out  pckg_sz  RX head packet.
- `rx_count`  out  $clog2(depth+1)  RX occupancy.
- `err`  out  3  sticky flags: [0] TX write while full, [1] `pop` while empty, [2] RX overflow (push dropped).

## Operation
- Both FIFOs are first-word-fall-through: head is visible on `D_pop`/`rx_data` whenever non-empty; contents undefined when empty.
- TX write: `tx_wr` stores `tx_data` when not full, or when full and `pop` is asserted the same cycle (pop frees the slot first). Otherwise dropped and `err[0]` set.
- TX read: `pop` with `pndng`=1 advances head. `pop` with `pndng`=0 is ignored and sets `err[1]`.
- TX write on empty FIFO with simultaneous `pop`: the pop is an error (empty at the edge); the write is stored.
- RX write: `push` stores `D_push` when accepted (see Configuration) and not full, or full with `rx_rd` the same cycle. Full without `rx_rd`: dropped, `err[2]` set.
- RX read: `rx_rd` with `rx_valid`=0 ignored, no flag.
- Pointers are `$clog2(depth)` bits and wrap naturally; occupancy is a separate counter: +1 write only, −1 read only, unchanged on both.
- `err` bits clear only on reset.

## Timing
- Reset (async assert, sync-released by the edge): pointers, counts, `err` = 0; `pndng`, `rx_valid`, `tx_full` = 0; `D_pop`, `rx_data` = 0.
- Write-to-visible latency 1 cycle: `tx_wr` at edge N → `pndng`=1 and `D_pop` valid after edge N.
- `pop` at edge N → next entry on `D_pop` (or `pndng`=0) after edge N; no bubble under back-to-back pops.
- Flags and counts are registered; `D_pop`/`rx_data` are a combinational read of the registered array at the registered head pointer.
- Reset mid-transfer discards all contents; no partial state survives.

## Configuration
- `BUS_DEV_ADDR_FILTER_EN` defined: `push` accepted only if destination equals `id` or `broadcast`; others silently dropped (no error, no count change).
- Undefined: every `push` accepted regardless of destination.

## Structure
- Package `bus_pkg`: `ADDR_W` = 8, default broadcast constant, function `get_dest(pkt)` returning the top 8 bits.
- Sub-module `bus_fifo` (parameters `width`, `depth`; FWFT, count, full/empty, write-with-read-when-full rule) instantiated twice; the endpoint adds error flags and the RX filter.

## Test plan
- Reset low 20 ns, then write 3 packets 0x0011, 0x0122, 0x0233 → `pndng` rises one cycle after first write, `tx_count`=3, `D_pop`=0x0011; three pops return 0x0011, 0x0122, 0x0233, then `pndng`=0.
- Fill TX with 8 packets, 9th `tx_wr` without `pop` → dropped, `err[0]`=1, `tx_count`=8; 9th `tx_wr` with `pop` → accepted, count stays 8.
- `pop` on empty endpoint → no state change, `err[1]`=1.
- `id`=2, filter on: push 0x0255, 0x8F66, 0x0377 → `rx_count`=2, reads return 0x0255 then 0x8F66; filter off → `rx_count`=3.
- 9 pushes without `rx_rd` → `rx_count`=8, `err[2]`=1, first 8 packets preserved in order.
- Reset asserted with 4 entries queued in each FIFO → all outputs return to reset values immediately; post-reset write behaves as first write.
